// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MIPS writeback stage: M/W pipeline register, load extension, GRF write port
//
// Purpose:
//   Captures memory-stage results into the M/W register. Extends load data by
//   type and byte offset, then selects the GRF write value. Drives the GRF
//   write port and the forwarding source used by the D/E stages. Instructions
//   killed by an M-stage exception or interrupt become bubbles.
//
// Optional feature:
//   WB_TRACE_EN - when defined, prints one "time@pc: $rd <= data" line for
//   each writing instruction as it leaves W.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   m_valid, m_regwr    M slot holds an instruction / it writes a GPR
//   m_rd, m_pc8         destination register, PC + 8
//   m_wdsel             0 ALU, 1 load, 2 pc8 (link), 3 aux
//   m_alu, m_dmrd       ALU result (low bits = load offset), raw memory word
//   m_aux               HI/LO/CP0 read value
//   m_ldtype            0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu, others lw
//   stall, exc_kill     hold W register / kill the instruction being captured
//   A3, WD, RegWr, pc8  GRF write port and trace PC
//   w_valid, w_fwd_en   W slot valid / W result forwardable

module wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic        m_regwr,
    input  logic [4:0]  m_rd,
    input  logic [31:0] m_pc8,
    input  logic [1:0]  m_wdsel,
    input  logic [31:0] m_alu,
    input  logic [31:0] m_dmrd,
    input  logic [31:0] m_aux,
    input  logic [2:0]  m_ldtype,
    input  logic        stall,
    input  logic        exc_kill,
    output logic [4:0]  A3,
    output logic [31:0] WD,
    output logic        RegWr,
    output logic [31:0] pc8,
    output logic        w_valid,
    output logic        w_fwd_en
);

    localparam logic [1:0] WDSEL_ALU  = 2'd0;
    localparam logic [1:0] WDSEL_LOAD = 2'd1;
    localparam logic [1:0] WDSEL_PC8  = 2'd2;

    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    logic        valid_q,  valid_d;
    logic        regwr_q,  regwr_d;
    logic [4:0]  rd_q,     rd_d;
    logic [31:0] pc8_q,    pc8_d;
    logic [1:0]  wdsel_q,  wdsel_d;
    logic [31:0] alu_q,    alu_d;
    logic [31:0] dmrd_q,   dmrd_d;
    logic [31:0] aux_q,    aux_d;
    logic [2:0]  ldtype_q, ldtype_d;

    // Next-state. A stall holds every field. A kill still captures the slot
    // but clears valid, so a flush bubble enters W.
    always_comb begin
        valid_d  = valid_q;
        regwr_d  = regwr_q;
        rd_d     = rd_q;
        pc8_d    = pc8_q;
        wdsel_d  = wdsel_q;
        alu_d    = alu_q;
        dmrd_d   = dmrd_q;
        aux_d    = aux_q;
        ldtype_d = ldtype_q;
        if (!stall) begin
            valid_d  = m_valid & ~exc_kill;
            regwr_d  = m_regwr;
            rd_d     = m_rd;
            pc8_d    = m_pc8;
            wdsel_d  = m_wdsel;
            alu_d    = m_alu;
            dmrd_d   = m_dmrd;
            aux_d    = m_aux;
            ldtype_d = m_ldtype;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            regwr_q  <= 1'b0;
            rd_q     <= 5'd0;
            pc8_q    <= 32'd0;
            wdsel_q  <= 2'd0;
            alu_q    <= 32'd0;
            dmrd_q   <= 32'd0;
            aux_q    <= 32'd0;
            ldtype_q <= 3'd0;
        end else begin
            valid_q  <= valid_d;
            regwr_q  <= regwr_d;
            rd_q     <= rd_d;
            pc8_q    <= pc8_d;
            wdsel_q  <= wdsel_d;
            alu_q    <= alu_d;
            dmrd_q   <= dmrd_d;
            aux_q    <= aux_d;
            ldtype_q <= ldtype_d;
        end
    end

    // Load extension (little-endian). Halves use only off[1]. A misaligned
    // half has already been turned into an exception upstream.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        ld_byte = 8'd0;
        case (alu_q[1:0])
            2'd0:    ld_byte = dmrd_q[7:0];
            2'd1:    ld_byte = dmrd_q[15:8];
            2'd2:    ld_byte = dmrd_q[23:16];
            default: ld_byte = dmrd_q[31:24];
        endcase
        ld_half = alu_q[1] ? dmrd_q[31:16] : dmrd_q[15:0];

        ld_data = dmrd_q;
        case (ldtype_q)
            LD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            LD_LBU:  ld_data = {24'd0, ld_byte};
            LD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            LD_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = dmrd_q;
        endcase
    end

    logic        wr_en;
    logic [31:0] wd_sel;

    always_comb begin
        wd_sel = aux_q;
        case (wdsel_q)
            WDSEL_ALU:  wd_sel = alu_q;
            WDSEL_LOAD: wd_sel = ld_data;
            WDSEL_PC8:  wd_sel = pc8_q;
            default:    wd_sel = aux_q;
        endcase
    end

    // Writes to $0 are never issued, so forwarding never sees a fake $0.
    assign wr_en    = valid_q & regwr_q & (rd_q != 5'd0);
    assign RegWr    = wr_en;
    assign A3       = wr_en ? rd_q : 5'd0;
    assign WD       = wd_sel;
    assign pc8      = valid_q ? pc8_q : 32'd0;
    assign w_valid  = valid_q;
    assign w_fwd_en = wr_en;

`ifdef WB_TRACE_EN
    // Print only when the W instruction is about to be replaced. Repeated
    // presentations during a stall therefore print once.
    always_ff @(posedge clk) begin
        if (!reset && !stall && wr_en) begin
            $display("%0t@%h: $%0d <= %h", $time, pc8_q - 32'd8, rd_q, wd_sel);
        end
    end
`else
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed table-driven testbench for wb_stage

module tb_wb_stage;

    logic        clk;
    logic        reset;
    logic        m_valid;
    logic        m_regwr;
    logic [4:0]  m_rd;
    logic [31:0] m_pc8;
    logic [1:0]  m_wdsel;
    logic [31:0] m_alu;
    logic [31:0] m_dmrd;
    logic [31:0] m_aux;
    logic [2:0]  m_ldtype;
    logic        stall;
    logic        exc_kill;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic        RegWr;
    logic [31:0] pc8;
    logic        w_valid;
    logic        w_fwd_en;

    int checks;
    int failures;

    wb_stage dut (
        .clk      (clk),
        .reset    (reset),
        .m_valid  (m_valid),
        .m_regwr  (m_regwr),
        .m_rd     (m_rd),
        .m_pc8    (m_pc8),
        .m_wdsel  (m_wdsel),
        .m_alu    (m_alu),
        .m_dmrd   (m_dmrd),
        .m_aux    (m_aux),
        .m_ldtype (m_ldtype),
        .stall    (stall),
        .exc_kill (exc_kill),
        .A3       (A3),
        .WD       (WD),
        .RegWr    (RegWr),
        .pc8      (pc8),
        .w_valid  (w_valid),
        .w_fwd_en (w_fwd_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [1:0]  ws;
        logic [31:0] alu;
        logic [31:0] dm;
        logic [31:0] aux;
        logic [2:0]  lt;
        logic        kill;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        logic        e_rw;
        logic [31:0] e_pc8;
        logic        e_wv;
    } vec_t;

    function automatic vec_t mk(logic v, logic rw, logic [4:0] rd, logic [31:0] pc,
                                logic [1:0] ws, logic [31:0] alu, logic [31:0] dm,
                                logic [31:0] aux, logic [2:0] lt, logic kill,
                                logic [4:0] e_a3, logic [31:0] e_wd, logic e_rw,
                                logic [31:0] e_pc8, logic e_wv);
        vec_t r;
        r.v = v; r.rw = rw; r.rd = rd; r.pc = pc; r.ws = ws; r.alu = alu;
        r.dm = dm; r.aux = aux; r.lt = lt; r.kill = kill;
        r.e_a3 = e_a3; r.e_wd = e_wd; r.e_rw = e_rw; r.e_pc8 = e_pc8; r.e_wv = e_wv;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input logic [4:0] a3, input logic [31:0] wd,
                            input logic rw, input logic [31:0] p8, input logic wv);
        chk({nm, "_A3"},    {27'd0, A3},       {27'd0, a3});
        chk({nm, "_WD"},    WD,                wd);
        chk({nm, "_RegWr"}, {31'd0, RegWr},    {31'd0, rw});
        chk({nm, "_pc8"},   pc8,               p8);
        chk({nm, "_wv"},    {31'd0, w_valid},  {31'd0, wv});
        chk({nm, "_fwd"},   {31'd0, w_fwd_en}, {31'd0, rw});
    endtask

    task automatic drive(input vec_t x);
        m_valid = x.v; m_regwr = x.rw; m_rd = x.rd; m_pc8 = x.pc; m_wdsel = x.ws;
        m_alu = x.alu; m_dmrd = x.dm; m_aux = x.aux; m_ldtype = x.lt; exc_kill = x.kill;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] DM = 32'h80FF7F01;

    vec_t vecs[16];
    vec_t tmp;

    initial begin
        checks   = 0;
        failures = 0;

        //               v  rw rd  pc            ws alu           dm  aux           lt kill a3  wd            rw pc8           wv
        vecs[0]  = mk(1, 1, 8,  32'h00001008, 0, 32'h12345678, DM, 32'h0,        0, 0,   8,  32'h12345678, 1, 32'h00001008, 1);
        vecs[1]  = mk(1, 1, 2,  32'h0000100C, 1, 32'h10000002, DM, 32'h0,        1, 0,   2,  32'hFFFFFFFF, 1, 32'h0000100C, 1);
        vecs[2]  = mk(1, 1, 3,  32'h00001010, 1, 32'h10000003, DM, 32'h0,        2, 0,   3,  32'h00000080, 1, 32'h00001010, 1);
        vecs[3]  = mk(1, 1, 4,  32'h00001014, 1, 32'h10000002, DM, 32'h0,        3, 0,   4,  32'hFFFF80FF, 1, 32'h00001014, 1);
        vecs[4]  = mk(1, 1, 5,  32'h00001018, 1, 32'h10000000, DM, 32'h0,        4, 0,   5,  32'h00007F01, 1, 32'h00001018, 1);
        vecs[5]  = mk(1, 1, 6,  32'h0000101C, 1, 32'h10000000, DM, 32'h0,        1, 0,   6,  32'h00000001, 1, 32'h0000101C, 1);
        vecs[6]  = mk(1, 1, 7,  32'h00001020, 1, 32'h10000001, DM, 32'h0,        2, 0,   7,  32'h0000007F, 1, 32'h00001020, 1);
        vecs[7]  = mk(1, 1, 10, 32'h00001024, 1, 32'h10000003, DM, 32'h0,        4, 0,   10, 32'h000080FF, 1, 32'h00001024, 1);
        vecs[8]  = mk(1, 1, 11, 32'h00001028, 1, 32'h10000001, DM, 32'h0,        0, 0,   11, 32'h80FF7F01, 1, 32'h00001028, 1);
        vecs[9]  = mk(1, 1, 12, 32'h0000102C, 1, 32'h10000002, DM, 32'h0,        7, 0,   12, 32'h80FF7F01, 1, 32'h0000102C, 1);
        vecs[10] = mk(1, 1, 9,  32'h00001030, 0, 32'h00000009, DM, 32'h0,        0, 1,   0,  32'h00000009, 0, 32'h00000000, 0);
        vecs[11] = mk(1, 1, 0,  32'h00001034, 0, 32'h00000055, DM, 32'h0,        0, 0,   0,  32'h00000055, 0, 32'h00001034, 1);
        vecs[12] = mk(1, 1, 31, 32'h00003008, 2, 32'h00000077, DM, 32'h0,        0, 0,   31, 32'h00003008, 1, 32'h00003008, 1);
        vecs[13] = mk(1, 1, 13, 32'h0000103C, 3, 32'h00000011, DM, 32'hDEADBEEF, 0, 0,   13, 32'hDEADBEEF, 1, 32'h0000103C, 1);
        vecs[14] = mk(0, 1, 14, 32'h00001040, 0, 32'h00000022, DM, 32'h0,        0, 0,   0,  32'h00000022, 0, 32'h00000000, 0);
        vecs[15] = mk(1, 0, 15, 32'h00001044, 0, 32'h00000033, DM, 32'h0,        0, 0,   0,  32'h00000033, 0, 32'h00001044, 1);

        // Reset for two cycles with garbage on the M inputs.
        reset = 1'b1; stall = 1'b0;
        drive(vecs[0]);
        step();
        step();
        chk_outs("reset", 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        chk_outs("idle", 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);

        // Table: one capture per vector, checked one clock later.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            step();
            chk_outs($sformatf("v%0d", i), vecs[i].e_a3, vecs[i].e_wd, vecs[i].e_rw,
                     vecs[i].e_pc8, vecs[i].e_wv);
        end

        // Stall for 3 cycles: inputs change (including exc_kill), outputs stay frozen.
        @(negedge clk);
        drive(vecs[0]);
        step();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            stall = 1'b1;
            tmp = vecs[1 + c];
            tmp.kill = (c == 1);
            drive(tmp);
            step();
            chk_outs($sformatf("stall%0d", c), 5'd8, 32'h12345678, 1'b1, 32'h00001008, 1'b1);
        end
        // Release with exc_kill still high: the capture becomes a bubble.
        @(negedge clk);
        stall = 1'b0;
        tmp = vecs[12];
        tmp.kill = 1'b1;
        drive(tmp);
        step();
        chk_outs("rel_kill", 5'd0, 32'h00003008, 1'b0, 32'd0, 1'b0);

        // Back-to-back writes to the same register, in order, one cycle each.
        @(negedge clk);
        drive(mk(1, 1, 4, 32'h00002008, 0, 32'h000000A1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        chk_outs("b2b0", 5'd4, 32'h000000A1, 1'b1, 32'h00002008, 1'b1);
        @(negedge clk);
        drive(mk(1, 1, 4, 32'h0000200C, 0, 32'h000000B2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        chk_outs("b2b1", 5'd4, 32'h000000B2, 1'b1, 32'h0000200C, 1'b1);

        // Reset asserted mid-stall discards the held instruction.
        @(negedge clk);
        stall = 1'b1;
        drive(vecs[13]);
        step();
        chk_outs("prerst", 5'd4, 32'h000000B2, 1'b1, 32'h0000200C, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk_outs("rst_stall", 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        drive(vecs[12]);
        step();
        chk_outs("post_rst", 5'd31, 32'h00003008, 1'b1, 32'h00003008, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
